// File: rtl/morse_pattern_rx.sv
// Morse receiver: synchronizes an on/off line, times marks/spaces in units and emits dot/dash symbols,
// word-gap and error pulses. Optional input deglitcher enabled by defining MORSE_GLITCH_FILTER_EN.
module morse_pattern_rx #(
  parameter int CLKS_PER_UNIT = 2097152,
  parameter int MAX_ELEMS     = 6,
  parameter int GLITCH_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               sig_in,
  output logic                               sym_valid,
  output logic [MAX_ELEMS-1:0]               sym_bits,
  output logic [$clog2(MAX_ELEMS+1)-1:0]     sym_len,
  output logic                               word_gap,
  output logic                               err
);

  localparam int LEN_W = $clog2(MAX_ELEMS + 1);
  localparam int CYC_W = $clog2(CLKS_PER_UNIT);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_UNIT - 1);
  localparam logic [LEN_W-1:0] ELEMS_FULL = LEN_W'(MAX_ELEMS);

  if (CLKS_PER_UNIT < 2 || MAX_ELEMS < 1 || MAX_ELEMS > 7 || GLITCH_CYCLES < 1) begin : g_param_check
    $error("morse_pattern_rx: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_MARK, S_SPACE, S_GAP, S_ABORT} state_t;

  logic sync1_q, line_q, line_prev_q;

  // Sync flops reset high so a line already high at reset release produces no rise edge.
`ifdef MORSE_GLITCH_FILTER_EN
  localparam int GW = $clog2(GLITCH_CYCLES + 1);
  logic          sync2_q;
  logic [GW-1:0] glitch_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      line_q       <= 1'b1;
      glitch_cnt_q <= '0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      if (sync2_q == line_q) begin
        glitch_cnt_q <= '0;
      end else if (glitch_cnt_q == GW'(GLITCH_CYCLES - 1)) begin
        line_q       <= sync2_q;
        glitch_cnt_q <= '0;
      end else begin
        glitch_cnt_q <= glitch_cnt_q + 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= sig_in;
      line_q  <= sync1_q;
    end
  end
`endif

  logic rise, fall;
  assign rise = line_q & ~line_prev_q;
  assign fall = ~line_q & line_prev_q;

  state_t               state_q;
  logic [CYC_W-1:0]     cyc_cnt_q;
  logic [2:0]           unit_cnt_q;
  logic [MAX_ELEMS-1:0] elem_bits_q;
  logic [LEN_W-1:0]     elem_cnt_q;
  logic                 sym_valid_q, word_gap_q, err_q;
  logic [MAX_ELEMS-1:0] sym_bits_q;
  logic [LEN_W-1:0]     sym_len_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      cyc_cnt_q   <= '0;
      unit_cnt_q  <= '0;
      elem_bits_q <= '0;
      elem_cnt_q  <= '0;
      sym_valid_q <= 1'b0;
      sym_bits_q  <= '0;
      sym_len_q   <= '0;
      word_gap_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      line_prev_q <= line_q;
      sym_valid_q <= 1'b0;
      word_gap_q  <= 1'b0;
      err_q       <= 1'b0;
      if (cyc_cnt_q == CYC_LAST) begin
        cyc_cnt_q <= '0;
        if (unit_cnt_q != 3'd7) unit_cnt_q <= unit_cnt_q + 3'd1;
      end else begin
        cyc_cnt_q <= cyc_cnt_q + 1'b1;
      end
      // Every transition below restarts the duration measurement.
      case (state_q)
        S_IDLE: if (rise) begin
          state_q <= S_MARK; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end
        S_MARK: if (unit_cnt_q >= 3'd5) begin
          err_q <= 1'b1; elem_bits_q <= '0; elem_cnt_q <= '0;
          state_q <= S_ABORT; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end else if (fall) begin
          if (elem_cnt_q == ELEMS_FULL) begin
            err_q <= 1'b1; elem_bits_q <= '0; elem_cnt_q <= '0;
            state_q <= S_ABORT;
          end else begin
            elem_bits_q[elem_cnt_q] <= (unit_cnt_q >= 3'd2);
            elem_cnt_q <= elem_cnt_q + 1'b1;
            state_q    <= S_SPACE;
          end
          cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end
        S_SPACE: if (unit_cnt_q >= 3'd2) begin
          // A rise landing exactly on the threshold still starts the next symbol's mark.
          sym_valid_q <= 1'b1; sym_bits_q <= elem_bits_q; sym_len_q <= elem_cnt_q;
          elem_bits_q <= '0; elem_cnt_q <= '0;
          state_q <= rise ? S_MARK : S_GAP; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end else if (rise) begin
          state_q <= S_MARK; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end
        S_GAP: if (rise) begin
          state_q <= S_MARK; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end else if (unit_cnt_q >= 3'd5) begin
          word_gap_q <= 1'b1;
          state_q <= S_IDLE; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end
        S_ABORT: if (!line_q) begin
          state_q <= S_IDLE; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end
        default: begin
          state_q <= S_IDLE; cyc_cnt_q <= '0; unit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_bits  = sym_bits_q;
  assign sym_len   = sym_len_q;
  assign word_gap  = word_gap_q;
  assign err       = err_q;

endmodule
